wash_program_seq: RTL and testbench
===================================

// Module: wash_program_seq
// PURPOSE
//  Parametrised washing-machine program selector and sequencer. Latches a mode
//  from the user selector, then runs timed phases FILL->WASH->RINSE->SPIN, with
//  pause/resume, door interlock and latched error states. Sits between front-panel
//  inputs and the motor/valve drivers. Its state code output feeds display logic.
// PARAMETERS
//  MODE_W   3  selector/mode width
//  N_MODES  5  codes 1..N_MODES-1 valid (1=dry-only, 2..=wash, heavier as code rises); 0=menu
//  TIMER_W  8  phase counter width; require WASH_T*(N_MODES-2) < 2**TIMER_W
//  FILL_T   4  FILL duration, cycles (>=1)
//  WASH_T   6  WASH base duration; WASH lasts WASH_T*(mode-1) cycles
//  RINSE_T  4  RINSE duration, cycles (>=1)
//  SPIN_T   3  SPIN duration, cycles (>=1)
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        synchronous reset, active-low
//  sel        in   MODE_W   mode selector (0 = menu)
//  start      in   1        start request (level, sampled each cycle)
//  pause      in   1        level; 1 = hold current phase
//  door_closed in  1        1 = door locked/closed
//  ack_err    in   1        error acknowledge (level)
//  state_o    out  4        MENU0 ARMED1 FILL2 WASH3 RINSE4 SPIN5 PAUSED6 DONE7 ERRSEL8 ERRDOOR9
//  mode_o     out  MODE_W   latched mode
//  remaining  out  TIMER_W  cycles left in current phase minus 1
//  busy       out  1        1 in FILL/WASH/RINSE/SPIN/PAUSED
//  done       out  1        1 in DONE
//  err_code   out  2        0 none, 1 invalid sel, 2 door open
// BEHAVIOUR
//  - All outputs registered. rst==0 at clk edge: state MENU; all outputs 0. Overrides mid-run.
//  - MENU: sel==0 stay. 1<=sel<N_MODES -> ARMED, mode_o<=sel. sel>=N_MODES -> ERR_SEL.
//  - ARMED, priority order:
//    (1) sel>=N_MODES -> ERR_SEL.
//    (2) sel==0 -> MENU.
//    (3) sel!=mode_o -> re-latch, stay ARMED.
//    (4) start&!door_closed -> ERR_DOOR.
//    (5) start&door_closed -> FILL, or SPIN if mode_o==1.
//  - Phase entry loads remaining<=duration-1, decrements each cycle, advances when
//    remaining==0; each phase is exactly its duration in cycles.
//    WASH duration = WASH_T*(mode_o-1), computed at TIMER_W width.
//  - Order FILL->WASH->RINSE->SPIN->DONE; mode 1: SPIN->DONE only.
//  - While busy: sel and start ignored.
//    Priority: door_closed==0 -> ERR_DOOR (also from PAUSED) > pause > count.
//  - pause==1 in phase -> PAUSED next cycle. remaining frozen, phase saved.
//    pause==0 in PAUSED -> back to saved phase, count resumes from frozen value.
//  - DONE: hold while sel!=0. sel==0 -> MENU, mode_o<=0.
//  - ERR_SEL/ERR_DOOR: err_code held. Exit to MENU only when ack_err==1 && sel==0.
//    Exit clears err_code and mode_o.
//  - remaining==0 outside FILL/WASH/RINSE/SPIN/PAUSED. Unused state codes -> MENU.
// TESTING
//  - Reset: rst=0 mid-WASH -> next edge state_o=0, busy=0, remaining=0, mode_o=0.
//  - Normal run: sel=3, start=1, door=1 -> FILL 4, WASH 12, RINSE 4, SPIN 3 cycles;
//    state_o=7 and done=1 exactly 23 cycles after entering FILL.
//  - Dry-only: sel=1, start -> SPIN 3 cycles -> DONE. sel=0 -> MENU.
//  - Pause: pause=1 at WASH remaining=5 for 10 cycles -> state_o=6, remaining stays 5.
//    Release -> WASH resumes at 5, total WASH still 12 active cycles.
//  - Door: door_closed=0 during RINSE, or during PAUSED -> ERR_DOOR, err_code=2.
//    ack_err=1, sel=0 -> MENU.
//  - Invalid sel=6 in MENU -> ERR_SEL, err_code=1. ack_err=1 with sel=6 -> stays.
//    sel=0, ack_err=1 -> MENU.

Source files
------------

// File: rtl/wash_program_seq_if.sv
// Front-panel / driver-side signal bundle for the wash program sequencer.
// master = front panel (drives the inputs), slave = sequencer.
interface wash_program_seq_if #(
    parameter int unsigned MODE_W  = 3,
    parameter int unsigned TIMER_W = 8
);
    logic [MODE_W-1:0]  sel;
    logic               start;
    logic               pause;
    logic               door_closed;
    logic               ack_err;
    logic [3:0]         state_o;
    logic [MODE_W-1:0]  mode_o;
    logic [TIMER_W-1:0] remaining;
    logic               busy;
    logic               done;
    logic [1:0]         err_code;

    modport master (
        output sel, start, pause, door_closed, ack_err,
        input  state_o, mode_o, remaining, busy, done, err_code
    );

    modport slave (
        input  sel, start, pause, door_closed, ack_err,
        output state_o, mode_o, remaining, busy, done, err_code
    );
endinterface

// File: rtl/wash_program_seq.sv
// Washing-machine program selector and phase sequencer (FILL->WASH->RINSE->SPIN)
// with pause/resume, door interlock and latched error states. All outputs registered.
module wash_program_seq #(
    parameter int unsigned MODE_W  = 3,
    parameter int unsigned N_MODES = 5,
    parameter int unsigned TIMER_W = 8,
    parameter int unsigned FILL_T  = 4,
    parameter int unsigned WASH_T  = 6,
    parameter int unsigned RINSE_T = 4,
    parameter int unsigned SPIN_T  = 3
) (
    input  logic                clk,
    input  logic                rst,
    wash_program_seq_if.slave   bus
);

    typedef enum logic [3:0] {
        StMenu    = 4'd0,
        StArmed   = 4'd1,
        StFill    = 4'd2,
        StWash    = 4'd3,
        StRinse   = 4'd4,
        StSpin    = 4'd5,
        StPaused  = 4'd6,
        StDone    = 4'd7,
        StErrSel  = 4'd8,
        StErrDoor = 4'd9
    } state_e;

    localparam logic [TIMER_W-1:0] FillLoad  = TIMER_W'(FILL_T - 1);
    localparam logic [TIMER_W-1:0] RinseLoad = TIMER_W'(RINSE_T - 1);
    localparam logic [TIMER_W-1:0] SpinLoad  = TIMER_W'(SPIN_T - 1);

    state_e              state_q, state_d, saved_q, saved_d;
    logic [MODE_W-1:0]   mode_q, mode_d;
    logic [TIMER_W-1:0]  rem_q, rem_d;
    logic [1:0]          err_q, err_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic [TIMER_W-1:0]  wash_len;
    logic                sel_bad;

    assign wash_len = TIMER_W'(WASH_T) * (TIMER_W'(mode_q) - TIMER_W'(1));
    assign sel_bad  = 32'(bus.sel) >= N_MODES;

    always_comb begin
        state_d = state_q;
        saved_d = saved_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        err_d   = err_q;
        case (state_q)
            StMenu: begin
                if (sel_bad) begin
                    state_d = StErrSel;
                    err_d   = 2'd1;
                end else if (bus.sel != '0) begin
                    state_d = StArmed;
                    mode_d  = bus.sel;
                end
            end
            StArmed: begin
                if (sel_bad) begin
                    state_d = StErrSel;
                    err_d   = 2'd1;
                end else if (bus.sel == '0) begin
                    state_d = StMenu;
                    mode_d  = '0;
                end else if (bus.sel != mode_q) begin
                    mode_d = bus.sel;
                end else if (bus.start && !bus.door_closed) begin
                    state_d = StErrDoor;
                    err_d   = 2'd2;
                end else if (bus.start) begin
                    if (mode_q == MODE_W'(1)) begin
                        state_d = StSpin;
                        rem_d   = SpinLoad;
                    end else begin
                        state_d = StFill;
                        rem_d   = FillLoad;
                    end
                end
            end
            StFill, StWash, StRinse, StSpin: begin
                if (!bus.door_closed) begin
                    state_d = StErrDoor;
                    err_d   = 2'd2;
                    rem_d   = '0;
                end else if (bus.pause) begin
                    // The sampled pause cycle does not count; remaining is frozen as shown.
                    state_d = StPaused;
                    saved_d = state_q;
                end else if (rem_q == '0) begin
                    case (state_q)
                        StFill: begin
                            state_d = StWash;
                            rem_d   = wash_len - TIMER_W'(1);
                        end
                        StWash: begin
                            state_d = StRinse;
                            rem_d   = RinseLoad;
                        end
                        StRinse: begin
                            state_d = StSpin;
                            rem_d   = SpinLoad;
                        end
                        default: begin
                            state_d = StDone;
                            rem_d   = '0;
                        end
                    endcase
                end else begin
                    rem_d = rem_q - TIMER_W'(1);
                end
            end
            StPaused: begin
                if (!bus.door_closed) begin
                    state_d = StErrDoor;
                    err_d   = 2'd2;
                    rem_d   = '0;
                end else if (!bus.pause) begin
                    state_d = saved_q;
                end
            end
            StDone: begin
                if (bus.sel == '0) begin
                    state_d = StMenu;
                    mode_d  = '0;
                end
            end
            StErrSel, StErrDoor: begin
                if (bus.ack_err && bus.sel == '0) begin
                    state_d = StMenu;
                    err_d   = 2'd0;
                    mode_d  = '0;
                end
            end
            default: begin
                state_d = StMenu;
                mode_d  = '0;
                rem_d   = '0;
                err_d   = 2'd0;
            end
        endcase
        busy_d = (state_d == StFill) || (state_d == StWash) || (state_d == StRinse) ||
                 (state_d == StSpin) || (state_d == StPaused);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StMenu;
            saved_q <= StFill;
            mode_q  <= '0;
            rem_q   <= '0;
            err_q   <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.state_o   = state_q;
    assign bus.mode_o    = mode_q;
    assign bus.remaining = rem_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err_code  = err_q;

endmodule

// File: tb/tb_wash_program_seq.sv
// Directed bench for wash_program_seq: reset, normal/dry runs, pause, door and selector errors.
module tb_wash_program_seq;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    wash_program_seq_if #(.MODE_W(3), .TIMER_W(8)) bus ();

    wash_program_seq #(
        .MODE_W(3), .N_MODES(5), .TIMER_W(8),
        .FILL_T(4), .WASH_T(6), .RINSE_T(4), .SPIN_T(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [31:0] st, input logic [31:0] rem);
        chk({tag, "_state"}, 32'(bus.state_o), st);
        chk({tag, "_rem"}, 32'(bus.remaining), rem);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst             = 1'b0;
        bus.sel         = '0;
        bus.start       = 1'b0;
        bus.pause       = 1'b0;
        bus.door_closed = 1'b1;
        bus.ack_err     = 1'b0;
        step(2);
        chk_st("reset", 0, 0);
        chk("reset_mode", 32'(bus.mode_o), 0);
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_done", 32'(bus.done), 0);
        chk("reset_err", 32'(bus.err_code), 0);
        rst = 1'b1;

        // Normal run, mode 3: 4 + 12 + 4 + 3 = 23 cycles from FILL entry to DONE.
        bus.sel = 3'd3;
        step();
        chk_st("armed", 1, 0);
        chk("armed_mode", 32'(bus.mode_o), 3);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk_st("fill_entry", 2, 3);
        chk("fill_busy", 32'(bus.busy), 1);
        step(3);
        chk_st("fill_last", 2, 0);
        step();
        chk_st("wash_entry", 3, 11);
        step(11);
        chk_st("wash_last", 3, 0);
        step();
        chk_st("rinse_entry", 4, 3);
        step(4);
        chk_st("spin_entry", 5, 2);
        step(2);
        chk_st("spin_last", 5, 0);
        step();
        chk_st("done_t23", 7, 0);
        chk("done_flag", 32'(bus.done), 1);
        chk("done_busy", 32'(bus.busy), 0);
        step();
        chk_st("done_hold", 7, 0);
        bus.sel = 3'd0;
        step();
        chk_st("done_exit", 0, 0);
        chk("done_exit_mode", 32'(bus.mode_o), 0);

        // Dry-only: straight to SPIN.
        bus.sel = 3'd1;
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk_st("dry_spin", 5, 2);
        step(3);
        chk_st("dry_done", 7, 0);
        bus.sel = 3'd0;
        step();
        chk_st("dry_menu", 0, 0);

        // Pause at WASH remaining=5 for 10 cycles.
        bus.sel = 3'd3;
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step(4);
        chk_st("p_wash_entry", 3, 11);
        step(6);
        chk_st("p_wash_5", 3, 5);
        bus.pause = 1'b1;
        step();
        chk_st("paused_first", 6, 5);
        chk("paused_busy", 32'(bus.busy), 1);
        step(9);
        chk_st("paused_last", 6, 5);
        bus.pause = 1'b0;
        step();
        chk_st("resumed", 3, 5);
        n = 1;
        while (bus.state_o == 4'd3 && n < 20) begin
            step();
            if (bus.state_o == 4'd3) n++;
        end
        chk("resumed_wash_cycles", 32'(n), 6);
        chk_st("p_rinse", 4, 3);
        step();
        bus.door_closed = 1'b0;
        step();
        chk_st("door_rinse", 9, 0);
        chk("door_rinse_err", 32'(bus.err_code), 2);
        chk("door_rinse_busy", 32'(bus.busy), 0);
        bus.ack_err = 1'b1;
        step();
        chk_st("door_ack_sel", 9, 0);
        bus.sel = 3'd0;
        step();
        chk_st("door_exit", 0, 0);
        chk("door_exit_err", 32'(bus.err_code), 0);
        chk("door_exit_mode", 32'(bus.mode_o), 0);
        bus.ack_err     = 1'b0;
        bus.door_closed = 1'b1;

        // Door opened while PAUSED in FILL; mode 2.
        bus.sel = 3'd2;
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.pause = 1'b1;
        step();
        chk_st("fill_paused", 6, 3);
        bus.door_closed = 1'b0;
        step();
        chk_st("door_paused", 9, 0);
        chk("door_paused_err", 32'(bus.err_code), 2);
        bus.pause   = 1'b0;
        bus.ack_err = 1'b1;
        bus.sel     = 3'd0;
        step();
        chk_st("door_paused_exit", 0, 0);
        bus.ack_err     = 1'b0;
        bus.door_closed = 1'b1;

        // Invalid selector.
        bus.sel = 3'd6;
        step();
        chk_st("errsel", 8, 0);
        chk("errsel_code", 32'(bus.err_code), 1);
        bus.ack_err = 1'b1;
        step();
        chk_st("errsel_hold", 8, 0);
        bus.sel = 3'd0;
        step();
        chk_st("errsel_exit", 0, 0);
        chk("errsel_exit_code", 32'(bus.err_code), 0);
        bus.ack_err = 1'b0;

        // ARMED re-latch, then out-of-range selector from ARMED.
        bus.sel = 3'd2;
        step();
        bus.sel   = 3'd4;
        bus.start = 1'b1;
        step();
        chk_st("relatch", 1, 0);
        chk("relatch_mode", 32'(bus.mode_o), 4);
        bus.start = 1'b0;
        bus.sel   = 3'd5;
        step();
        chk_st("armed_errsel", 8, 0);
        bus.sel     = 3'd0;
        bus.ack_err = 1'b1;
        step();
        bus.ack_err = 1'b0;
        chk_st("armed_errsel_exit", 0, 0);

        // Start with the door open.
        bus.sel = 3'd2;
        step();
        bus.door_closed = 1'b0;
        bus.start       = 1'b1;
        step();
        chk_st("start_door_open", 9, 0);
        bus.start       = 1'b0;
        bus.door_closed = 1'b1;
        bus.sel         = 3'd0;
        bus.ack_err     = 1'b1;
        step();
        bus.ack_err = 1'b0;
        chk_st("start_door_exit", 0, 0);

        // Mode 2 WASH is 6 cycles; reset in mid-WASH.
        bus.sel = 3'd2;
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step(4);
        chk_st("m2_wash_entry", 3, 5);
        step();
        rst = 1'b0;
        step();
        chk_st("mid_reset", 0, 0);
        chk("mid_reset_busy", 32'(bus.busy), 0);
        chk("mid_reset_mode", 32'(bus.mode_o), 0);
        rst = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
